// File: rtl/modexp_stream_adapter.sv
// Host-side adapter for the word-serial ModExp core.
// The host writes five operand arrays (m, e, n, r, t) through a tagged, addressed
// valid/ready port. On go, the adapter streams the operands to the core one word
// per cycle, arms the computation and waits for COMPLETE. It then reads the result
// words into a buffer and presents them to the host under back-pressure.
module modexp_stream_adapter #(
    parameter int  KEY_WIDTH     = 4096,
    parameter int  WORD_WIDTH    = 64,
    parameter int  COMPLETE_CODE = 9,
    localparam int NUM_WORDS     = KEY_WIDTH / WORD_WIDTH,
    localparam int AW            = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    // host write port
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_sel,
    input  logic [AW-1:0]         in_addr,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic [WORD_WIDTH-1:0] nprime0,
    input  logic                  go,
    output logic                  busy,
    // core side
    output logic [WORD_WIDTH-1:0] core_m_buf,
    output logic [WORD_WIDTH-1:0] core_e_buf,
    output logic [WORD_WIDTH-1:0] core_n_buf,
    output logic [WORD_WIDTH-1:0] core_r_buf,
    output logic [WORD_WIDTH-1:0] core_t_buf,
    output logic [WORD_WIDTH-1:0] core_nprime0,
    output logic                  core_start_input,
    output logic                  core_start_compute,
    output logic                  core_get_result,
    input  logic [4:0]            core_exp_state,
    input  logic [WORD_WIDTH-1:0] core_res_out,
    // host result stream
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  done
);

    // The counter must reach NUM_WORDS during READ, hence one extra bit.
    localparam int            CW        = AW + 1;
    localparam int            NUM_OPS   = 5;
    localparam logic [CW-1:0] LAST_WORD = CW'(NUM_WORDS - 1);
    localparam logic [CW-1:0] READ_END  = CW'(NUM_WORDS);
    localparam logic [4:0]    COMPLETE  = 5'(COMPLETE_CODE);
    localparam logic [2:0]    MAX_SEL   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_ARM,
        S_WAIT,
        S_READ,
        S_DRAIN
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    // Operand and result storage; never reset so operands persist across runs.
    logic [WORD_WIDTH-1:0]   opnd_mem [NUM_OPS][NUM_WORDS];
    logic [WORD_WIDTH-1:0]   res_mem  [NUM_WORDS];

    logic                    wr_en;
    logic                    go_take;
    logic                    cap_en;
    logic [AW-1:0]           cap_addr;
    logic [AW-1:0]           send_addr;

    logic [WORD_WIDTH-1:0]   buf_q [NUM_OPS];
    logic [WORD_WIDTH-1:0]   buf_d [NUM_OPS];
    logic [WORD_WIDTH-1:0]   nprime0_q, nprime0_d;
    logic                    start_input_q, start_input_d;
    logic                    start_compute_q, start_compute_d;
    logic                    get_result_q, get_result_d;

    assign in_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign wr_en    = in_valid && in_ready && (in_sel <= MAX_SEL);
    assign go_take  = go && (state_q == S_IDLE);

    // Read-out word k lands in result slot k-1; slot index for the capture write.
    assign cap_addr = AW'(cnt_q - 1'b1);

    assign out_valid = (state_q == S_DRAIN);
    assign out_data  = out_valid ? res_mem[cnt_q[AW-1:0]] : '0;
    assign out_last  = out_valid && (cnt_q == LAST_WORD);
    assign done      = out_last && out_ready;

    assign core_m_buf         = buf_q[0];
    assign core_e_buf         = buf_q[1];
    assign core_n_buf         = buf_q[2];
    assign core_r_buf         = buf_q[3];
    assign core_t_buf         = buf_q[4];
    assign core_nprime0       = nprime0_q;
    assign core_start_input   = start_input_q;
    assign core_start_compute = start_compute_q;
    assign core_get_result    = get_result_q;

    // Next-state and word-counter sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_SEND;
                    cnt_d   = '0;
                end
            end
            S_SEND: begin
                if (cnt_q == LAST_WORD) begin
                    state_d = S_ARM;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ARM: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (core_exp_state == COMPLETE) begin
                    state_d = S_READ;
                    cnt_d   = '0;
                end
            end
            S_READ: begin
                // The core's first read-out cycle carries no valid word.
                cap_en = (cnt_q != '0);
                if (cnt_q == READ_END) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (cnt_q == LAST_WORD) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Core-facing outputs are computed from the next state so that the registered
    // copies line up with the state they belong to (go -> first word in one cycle).
    always_comb begin
        send_addr       = cnt_d[AW-1:0];
        start_input_d   = (state_d == S_SEND);
        start_compute_d = (state_d == S_ARM) || (state_d == S_READ);
        get_result_d    = (state_d == S_ARM);
        nprime0_d       = go_take ? nprime0 : nprime0_q;
        for (int i = 0; i < NUM_OPS; i++) begin
            buf_d[i] = '0;
            if (state_d == S_SEND) begin
                buf_d[i] = opnd_mem[i][send_addr];
                // A write issued together with go must reach the core in the same run.
                if (wr_en && (in_sel == 3'(i)) && (in_addr == send_addr)) begin
                    buf_d[i] = in_data;
                end
            end
        end
    end

    // State, counter and registered core controls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            nprime0_q       <= '0;
            start_input_q   <= 1'b0;
            start_compute_q <= 1'b0;
            get_result_q    <= 1'b0;
            for (int i = 0; i < NUM_OPS; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            nprime0_q       <= nprime0_d;
            start_input_q   <= start_input_d;
            start_compute_q <= start_compute_d;
            get_result_q    <= get_result_d;
            for (int i = 0; i < NUM_OPS; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    // Operand writes from the host and result capture from the core.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            opnd_mem[in_sel][in_addr] <= in_data;
        end
        if (cap_en) begin
            res_mem[cap_addr] <= core_res_out;
        end
    end

endmodule

// File: doc/modexp_stream_adapter.md
# modexp_stream_adapter

Parametrised host-side adapter for the word-serial `ModExp` core. It collects the five key-width operands (m, e, n, r, t) through a tagged, addressed valid/ready write port. It replays them to the core one word per cycle, arms the computation and waits for the core's COMPLETE exponent state. It then captures the result words into a buffer and streams them out under back-pressure. It replaces ad-hoc bench sequencing and generalises key width and word width.

## Interface
- `KEY_WIDTH`, default 4096: operand width in bits; must be a multiple of `WORD_WIDTH`.
- `WORD_WIDTH`, default 64: core bus word width.
- `NUM_WORDS`, derived = `KEY_WIDTH/WORD_WIDTH`: words per operand.
- `AW`, derived = clog2(`NUM_WORDS`): word-address width.
- `COMPLETE_CODE`, default 9: `core_exp_state` value meaning the result is ready.
- `clk`, input, 1: clock.
- `reset`, input, 1: reset, synchronous, active-high.
- `in_valid`, input, 1: host write request.
- `in_ready`, output, 1: adapter accepts a write; high only in IDLE.
- `in_sel`, input, 3: operand tag (0=m, 1=e, 2=n, 3=r, 4=t; 5-7 reserved).
- `in_addr`, input, `AW`: word index; 0 is the least-significant word.
- `in_data`, input, `WORD_WIDTH`: write data.
- `nprime0`, input, `WORD_WIDTH`: −n⁻¹ mod 2^`WORD_WIDTH`; sampled at `go`.
- `go`, input, 1: start pulse; honoured only in IDLE.
- `busy`, output, 1: high in every state except IDLE.
- `core_m_buf`, `core_e_buf`, `core_n_buf`, `core_r_buf`, `core_t_buf`, output, `WORD_WIDTH` each: operand words to the core.
- `core_nprime0`, output, `WORD_WIDTH`: registered copy of `nprime0`.
- `core_start_input`, `core_start_compute`, `core_get_result`, output, 1 each: core controls.
- `core_exp_state`, input, 5: core exponent FSM state.
- `core_res_out`, input, `WORD_WIDTH`: core result word.
- `out_valid`, output, 1: result word available.
- `out_ready`, input, 1: host consumes the word.
- `out_data`, output, `WORD_WIDTH`: result word, least-significant word first.
- `out_last`, output, 1: marks word `NUM_WORDS`−1.
- `done`, output, 1: one-cycle pulse when the last result word is accepted.

## Operation
- Storage: five `NUM_WORDS`×`WORD_WIDTH` operand arrays and one result array.
- Writes occur when `in_valid & in_ready`. Reserved `in_sel` values are accepted and discarded. Arrays persist across runs, so only changed operands need rewriting.
- FSM states: IDLE, SEND, ARM, WAIT, READ, DRAIN.
- IDLE → SEND on `go`. `nprime0` is latched into `core_nprime0` and the word counter is cleared. `go` and a write in the same cycle: the write completes first and `go` is taken.
- SEND: `NUM_WORDS` cycles. In cycle i, `core_*_buf` = word i of each operand and `core_start_input`=1. After the cycle with i=`NUM_WORDS`−1, go to ARM.
- ARM: one cycle with `core_start_compute`=1 and `core_get_result`=1, then WAIT.
- WAIT: all core controls low. Leave for READ when `core_exp_state`==`COMPLETE_CODE`, counter cleared.
- READ: `NUM_WORDS`+1 cycles with `core_start_compute`=1. Counter value 0 is discarded. At counter value k (1..`NUM_WORDS`), `core_res_out` is written into result word k−1. The core cannot be stalled, so capture ignores `out_ready`. After k=`NUM_WORDS`, go to DRAIN.
- DRAIN: present result words 0..`NUM_WORDS`−1 with `out_valid`=1. Advance on `out_ready`. `out_last`=1 on the final word. `done` pulses on the cycle the final word is accepted; the next state is IDLE.
- `go` outside IDLE is ignored.

## Timing
- Reset (synchronous) forces IDLE, counters 0, and all outputs 0 except `in_ready`=1. This holds from any state, including mid-SEND, mid-READ and mid-DRAIN. Operand arrays are not cleared. The core must be reset alongside the adapter.
- Every `core_*` output is registered.
- Latency from the `go` cycle to the first `core_start_input`=1: 1 cycle.
- SEND lasts exactly `NUM_WORDS` cycles and ARM exactly 1. READ starts the cycle after COMPLETE is first seen and lasts `NUM_WORDS`+1 cycles.
- In DRAIN, `out_data` and `out_last` hold stable while `out_valid & ~out_ready`. There is no bubble between consecutive accepted words.
- `in_ready` drops the cycle after `go` is taken and returns the cycle after `done`.

## Test plan
- Load with `KEY_WIDTH`=256, `WORD_WIDTH`=64, m=8, e=13, n=77, against a behavioural core returning m^e mod n -> SEND shows words 0..3 in order over 4 cycles. ARM lasts one cycle. The output stream is 50,0,0,0 with `out_last` on the 4th word and a single `done` pulse.
- Full 4096/64 run with the team's reference RSA vector -> 64 SEND cycles, 65 READ cycles, and 64 output words equal to the golden ciphertext.
- Random `out_ready` stalls (50%) during DRAIN -> no word is lost or duplicated and `out_data` is stable while stalled.
- Write attempts and `go` while busy -> `in_ready`=0, arrays unchanged (compared on the next run), no restart.
- Rewrite only m at address 2 between runs -> the second run uses the new m and the retained e, n, r, t.
- Reset asserted mid-READ (k=2) -> next cycle is IDLE, `busy`=0, `out_valid`=0. A following `go` completes normally.
